// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: steps each instruction through IF/ID/EXE/MEM/WB and decodes
// datapath controls. Define MCCTRL_RETIRE_CNT_EN to add the 32-bit 'retired' counter output.
module multi_cycle_ctrl #(
    parameter int unsigned    OPW     = 6,
    parameter logic [OPW-1:0] HALT_OP = OPW'(6'b111111)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] opCode,
    input  logic           zero,
    input  logic           sign,
    output logic [2:0]     state,
    output logic           PCWre,
    output logic           IRWre,
    output logic           InsMemRW,
    output logic           RegWre,
    output logic           mRD,
    output logic           mWR,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic           DBDataSrc,
    output logic           WrRegDSrc,
    output logic           ExtSel,
    output logic [1:0]     RegDst,
    output logic [1:0]     PCSrc,
    output logic [2:0]     ALUOp
`ifdef MCCTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]    retired
`endif
);

    localparam logic [OPW-1:0] OP_ADD   = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_AND   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_SLL   = OPW'(6'b011000);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b110100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b110101);
    localparam logic [OPW-1:0] OP_BLTZ  = OPW'(6'b110110);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b111000);
    localparam logic [OPW-1:0] OP_JR    = OPW'(6'b111001);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b111010);

    typedef enum logic [2:0] {
        StIf    = 3'b000,
        StId    = 3'b001,
        StExeLs = 3'b010,
        StMem   = 3'b011,
        StWbLd  = 3'b100,
        StExeBr = 3'b101,
        StExeAl = 3'b110,
        StWbAl  = 3'b111
    } state_e;

    state_e r_state;
    state_e w_state_nxt;
    logic   w_is_alu, w_is_sw, w_is_lw, w_is_br, w_is_j, w_is_jr, w_is_jal, w_is_halt;
    logic   w_taken;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= StIf;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Opcode-only decode: these selects do not depend on the current state.
    always_comb begin
        w_is_alu = 1'b0;
        w_is_sw  = 1'b0;
        w_is_lw  = 1'b0;
        w_is_br  = 1'b0;
        w_is_j   = 1'b0;
        w_is_jr  = 1'b0;
        w_is_jal = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 1'b0;
        ExtSel   = 1'b1;
        RegDst   = 2'b01;
        ALUOp    = 3'b000;
        case (opCode)
            OP_ADD:   begin w_is_alu = 1'b1; RegDst = 2'b10; end
            OP_SUB:   begin w_is_alu = 1'b1; RegDst = 2'b10; ALUOp = 3'b001; end
            OP_ADDIU: begin w_is_alu = 1'b1; ALUSrcB = 1'b1; end
            OP_AND:   begin w_is_alu = 1'b1; RegDst = 2'b10; ALUOp = 3'b100; end
            OP_ANDI:  begin w_is_alu = 1'b1; ALUSrcB = 1'b1; ExtSel = 1'b0; ALUOp = 3'b100; end
            OP_ORI:   begin w_is_alu = 1'b1; ALUSrcB = 1'b1; ExtSel = 1'b0; ALUOp = 3'b011; end
            OP_SLL:   begin w_is_alu = 1'b1; ALUSrcA = 1'b1; RegDst = 2'b10; ALUOp = 3'b010; end
            OP_SLTI:  begin w_is_alu = 1'b1; ALUSrcB = 1'b1; ALUOp = 3'b101; end
            OP_SW:    begin w_is_sw = 1'b1; ALUSrcB = 1'b1; end
            OP_LW:    begin w_is_lw = 1'b1; ALUSrcB = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLTZ: begin w_is_br = 1'b1; ALUOp = 3'b001; end
            OP_J:     w_is_j = 1'b1;
            OP_JR:    w_is_jr = 1'b1;
            OP_JAL:   begin w_is_jal = 1'b1; RegDst = 2'b00; end
            default:  ;
        endcase
    end

    assign w_is_halt = (opCode == HALT_OP);
    assign w_taken   = ((opCode == OP_BEQ) & zero) | ((opCode == OP_BNE) & ~zero) |
                       ((opCode == OP_BLTZ) & sign);

    always_comb begin
        w_state_nxt = r_state;
        PCWre       = 1'b0;
        RegWre      = 1'b0;
        mRD         = 1'b0;
        mWR         = 1'b0;
        PCSrc       = 2'b00;
        if (w_is_j | w_is_jal) begin
            PCSrc = 2'b11;
        end else if (w_is_jr) begin
            PCSrc = 2'b10;
        end
        case (r_state)
            StIf: w_state_nxt = StId;
            StId: begin
                if (w_is_halt) begin
                    w_state_nxt = StId;
                end else if (w_is_br) begin
                    w_state_nxt = StExeBr;
                end else if (w_is_sw | w_is_lw) begin
                    w_state_nxt = StExeLs;
                end else if (w_is_alu) begin
                    w_state_nxt = StExeAl;
                end else begin
                    // Jumps and unknown opcodes retire straight out of ID.
                    w_state_nxt = StIf;
                    PCWre       = 1'b1;
                    RegWre      = w_is_jal;
                end
            end
            StExeBr: begin
                w_state_nxt = StIf;
                PCWre       = 1'b1;
                if (w_taken) PCSrc = 2'b01;
            end
            StExeLs: w_state_nxt = StMem;
            StMem: begin
                if (w_is_lw) begin
                    w_state_nxt = StWbLd;
                    mRD         = 1'b1;
                end else begin
                    w_state_nxt = StIf;
                    mWR         = 1'b1;
                    PCWre       = 1'b1;
                end
            end
            StWbLd: begin
                w_state_nxt = StIf;
                PCWre       = 1'b1;
                RegWre      = 1'b1;
            end
            StExeAl: w_state_nxt = StWbAl;
            StWbAl: begin
                w_state_nxt = StIf;
                PCWre       = 1'b1;
                RegWre      = 1'b1;
            end
            default: w_state_nxt = StIf;
        endcase
    end

    assign state     = r_state;
    assign IRWre     = (r_state == StIf);
    assign InsMemRW  = 1'b1;
    assign DBDataSrc = w_is_lw;
    assign WrRegDSrc = ~w_is_jal;

`ifdef MCCTRL_RETIRE_CNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_retired <= '0;
        end else if (PCWre) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed vector table, corner sequences, and a
// randomized instruction stream checked against a per-instruction path model.
module tb_multi_cycle_ctrl;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam int C_JMP = 0, C_BR = 1, C_SW = 2, C_LW = 3, C_ALU = 4, C_HALT = 5;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [5:0]  opCode = OP_ADD;
    logic        zero = 1'b0;
    logic        sign = 1'b0;
    logic [2:0]  state;
    logic        PCWre, IRWre, InsMemRW, RegWre, mRD, mWR;
    logic        ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
    logic [1:0]  RegDst, PCSrc;
    logic [2:0]  ALUOp;
`ifdef MCCTRL_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    always #5 CLK = ~CLK;

    multi_cycle_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .opCode    (opCode),
        .zero      (zero),
        .sign      (sign),
        .state     (state),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .InsMemRW  (InsMemRW),
        .RegWre    (RegWre),
        .mRD       (mRD),
        .mWR       (mWR),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .DBDataSrc (DBDataSrc),
        .WrRegDSrc (WrRegDSrc),
        .ExtSel    (ExtSel),
        .RegDst    (RegDst),
        .PCSrc     (PCSrc),
        .ALUOp     (ALUOp)
`ifdef MCCTRL_RETIRE_CNT_EN
        ,
        .retired   (retired)
`endif
    );

    wire [20:0] dut_vec = {state, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
                           DBDataSrc, WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp};
    wire [17:0] dut_short = {state, PCWre, IRWre, RegWre, mRD, mWR, PCSrc, RegDst, ALUOp,
                             DBDataSrc, WrRegDSrc, ALUSrcB};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic int op_class(input logic [5:0] op);
        if (op == OP_HALT) return C_HALT;
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL, OP_SLTI: return C_ALU;
            OP_SW:                    return C_SW;
            OP_LW:                    return C_LW;
            OP_BEQ, OP_BNE, OP_BLTZ:  return C_BR;
            default:                  return C_JMP;
        endcase
    endfunction

    // Cycles per instruction class.
    function automatic int op_len(input int c);
        case (c)
            C_JMP:   return 2;
            C_BR:    return 3;
            C_SW:    return 4;
            C_ALU:   return 4;
            C_LW:    return 5;
            default: return 1000;
        endcase
    endfunction

    function automatic logic [2:0] path_state(input int c, input int step);
        if (step == 0) return 3'd0;
        if (step == 1 || c == C_JMP || c == C_HALT) return 3'd1;
        case (c)
            C_BR:    return 3'd5;
            C_ALU:   return (step == 2) ? 3'd6 : 3'd7;
            default: return (step == 2) ? 3'd2 : ((step == 3) ? 3'd3 : 3'd4);
        endcase
    endfunction

    function automatic logic [20:0] model_vec(input logic [5:0] op, input int step,
                                             input logic z, input logic s);
        int         c;
        logic       last, taken;
        logic [1:0] rdst, pcsrc;
        logic [2:0] aluop;
        c     = op_class(op);
        last  = (c != C_HALT) && (step == op_len(c) - 1);
        taken = (op == OP_BEQ && z) || (op == OP_BNE && !z) || (op == OP_BLTZ && s);
        if (op == OP_JAL) rdst = 2'd0;
        else if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_SLL) rdst = 2'd2;
        else rdst = 2'd1;
        if (op == OP_J || op == OP_JAL) pcsrc = 2'd3;
        else if (op == OP_JR) pcsrc = 2'd2;
        else if (c == C_BR && step == 2 && taken) pcsrc = 2'd1;
        else pcsrc = 2'd0;
        case (op)
            OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: aluop = 3'd1;
            OP_SLL:                          aluop = 3'd2;
            OP_ORI:                          aluop = 3'd3;
            OP_AND, OP_ANDI:                 aluop = 3'd4;
            OP_SLTI:                         aluop = 3'd5;
            default:                         aluop = 3'd0;
        endcase
        return {path_state(c, step), last, step == 0, 1'b1,
                last && (c == C_ALU || c == C_LW || op == OP_JAL),
                c == C_LW && step == 3, c == C_SW && step == 3,
                op == OP_SLL,
                op == OP_ADDIU || op == OP_ANDI || op == OP_ORI || op == OP_SLTI ||
                    op == OP_SW || op == OP_LW,
                op == OP_LW, op != OP_JAL, !(op == OP_ANDI || op == OP_ORI),
                rdst, pcsrc, aluop};
    endfunction

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       s;
        int         step;
        logic [2:0] st;
        logic       pcw, irw, rw, rd, wr;
        logic [1:0] pcsrc, rdst;
        logic [2:0] aluop;
        logic       dbs, wrs, srcb;
    } vec_t;

    vec_t tbl[15];

    task automatic do_reset;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    logic [5:0] known[16];
    logic [5:0] r_op;
    int         cls;
    int         exp_ret;

    initial begin
        tbl[0]  = '{OP_ADD,  1'b0, 1'b0, 0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{OP_ADD,  1'b0, 1'b0, 3, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{OP_LW,   1'b0, 1'b0, 3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 3'd0, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{OP_LW,   1'b0, 1'b0, 4, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 3'd0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{OP_BEQ,  1'b1, 1'b0, 2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 3'd1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{OP_BEQ,  1'b0, 1'b0, 2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 3'd1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{OP_BLTZ, 1'b0, 1'b1, 2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 3'd1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{OP_BNE,  1'b1, 1'b0, 2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 3'd1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{OP_JAL,  1'b0, 1'b0, 1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{OP_SW,   1'b0, 1'b0, 3, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 3'd0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{OP_SLL,  1'b0, 1'b0, 2, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 3'd2, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{OP_ORI,  1'b0, 1'b0, 3, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 3'd3, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{OP_JR,   1'b0, 1'b0, 1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{6'b000111, 1'b0, 1'b0, 1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{OP_SLTI, 1'b0, 1'b0, 2, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 3'd5, 1'b0, 1'b1, 1'b1};
        known = '{OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL, OP_SLTI,
                  OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ, OP_J, OP_JR, OP_JAL};

        // Power-on reset.
        #50;
        check("in_reset_state", {29'b0, state}, 32'd0);
        check("in_reset_irwre", {31'b0, IRWre}, 32'd1);
        #50;
        RST = 1'b1;
        #1;
        check("reset_state", {29'b0, state}, 32'd0);
        check("reset_irwre", {31'b0, IRWre}, 32'd1);
        check("reset_pcwre", {31'b0, PCWre}, 32'd0);
        check("reset_regwre", {31'b0, RegWre}, 32'd0);
        @(negedge CLK);
        #1;
        check("first_id", {29'b0, state}, 32'd1);

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            do_reset();
            opCode = tbl[i].op;
            zero   = 1'b0;
            sign   = 1'b0;
            repeat (tbl[i].step) @(negedge CLK);
            zero = tbl[i].z;
            sign = tbl[i].s;
            #1;
            check($sformatf("vec%0d", i), {14'b0, dut_short},
                  {14'b0, tbl[i].st, tbl[i].pcw, tbl[i].irw, tbl[i].rw, tbl[i].rd, tbl[i].wr,
                   tbl[i].pcsrc, tbl[i].rdst, tbl[i].aluop, tbl[i].dbs, tbl[i].wrs,
                   tbl[i].srcb});
        end

        // HALT parks in ID with the PC frozen.
        do_reset();
        opCode = OP_HALT;
        @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("halt%0d", i), {11'b0, dut_vec},
                  {11'b0, model_vec(OP_HALT, 1, zero, sign)});
            @(negedge CLK);
        end

        // Reset during SW's MEM cycle drops the write immediately.
        do_reset();
        opCode = OP_SW;
        repeat (3) @(negedge CLK);
        #1;
        check("sw_mem_mwr", {31'b0, mWR}, 32'd1);
        #1;
        RST = 1'b0;
        #1;
        check("sw_abort_mwr", {31'b0, mWR}, 32'd0);
        check("sw_abort_state", {29'b0, state}, 32'd0);
        check("sw_abort_pcwre", {31'b0, PCWre}, 32'd0);
        check("sw_abort_irwre", {31'b0, IRWre}, 32'd1);
`ifdef MCCTRL_RETIRE_CNT_EN
        check("sw_abort_retired", retired, 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b1;

        // Random instruction stream.
        do_reset();
        exp_ret = 0;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) != 0) begin
                r_op = known[$urandom_range(0, 15)];
            end else begin
                r_op = 6'($urandom);
                if (r_op == OP_HALT) r_op = OP_ADD;
            end
            cls    = op_class(r_op);
            opCode = r_op;
            for (int st = 0; st < op_len(cls); st++) begin
                zero = 1'($urandom_range(0, 1));
                sign = 1'($urandom_range(0, 1));
                #1;
                check($sformatf("rand%0d.%0d op=%b", n, st, r_op), {11'b0, dut_vec},
                      {11'b0, model_vec(r_op, st, zero, sign)});
                @(negedge CLK);
            end
            exp_ret++;
        end
`ifdef MCCTRL_RETIRE_CNT_EN
        check("retired_count", retired, 32'(exp_ret));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
